// File: rtl/word_serializer32_pkg.sv
// Shared types and sizing for the word serializer: FSM state encoding and
// default word/counter widths.
package serializer_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage : serializer_pkg

// File: rtl/word_serializer32_if.sv
// Word-in / bit-out handshake bundle. The slave modport is the serializer
// itself; the master modport is the upstream producer plus serial consumer.
interface word_serializer32_if #(
  parameter int WIDTH = serializer_pkg::WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_bit;
  logic             ser_last;
  logic             word_zero;
  logic             word_done;

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_bit, ser_last, word_zero, word_done
  );

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_bit, ser_last, word_zero, word_done
  );

endinterface : word_serializer32_if

// File: rtl/word_serializer32_beat_counter.sv
// Beat position within the current word: clear has priority over enable,
// tc flags the final bit position.
module beat_counter #(
  parameter int WIDTH = serializer_pkg::WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking (<=) assignments
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule : beat_counter

// File: rtl/word_serializer32.sv
// Parallel-to-serial converter: takes a word on a valid/ready handshake and
// emits it LSB first, reporting whether the finished word was all zeros.
module word_serializer32
  import serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  word_serializer32_if.slave  bus
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic             nz_q;
  logic             word_zero_q;
  logic             word_done_q;

  logic             tc;
  logic             in_ready;
  logic             accept;
  logic             beat;
  logic             last_beat;
  logic             ser_valid;
  logic             ser_bit;
  logic             ser_last;

  beat_counter #(.WIDTH(WIDTH)) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept | last_beat),
    .en    (beat),
    .tc    (tc)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;
    in_ready  = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = shreg_q[0];
        ser_last  = tc;
        beat      = bus.ser_ready;
        last_beat = tc & bus.ser_ready;
        // The next word may load on the final beat, keeping the stream gapless.
        in_ready  = last_beat;
        if (last_beat && !bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      nz_q        <= 1'b0;
      word_zero_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_done_q <= last_beat;
      if (last_beat) word_zero_q <= ~(nz_q | shreg_q[0]);

      if (accept) begin
        shreg_q <= bus.in_data;
        nz_q    <= 1'b0;
      end else if (beat) begin
        shreg_q <= shreg_q >> 1;
        nz_q    <= nz_q | shreg_q[0];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_bit   = ser_bit;
  assign bus.ser_last  = ser_last;
  assign bus.word_zero = word_zero_q;
  assign bus.word_done = word_done_q;

endmodule : word_serializer32

// File: tb/tb_word_serializer32.sv
// Directed bench for word_serializer32: single words, zero detection,
// backpressure, back-to-back streaming and asynchronous reset mid-word.
module tb_word_serializer32;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  word_serializer32_if #(.WIDTH(32)) bus ();

  word_serializer32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one word with ser_ready held high and checks all 32 beats plus the
  // completion pulse. Called at a negedge with the serializer idle.
  task automatic test_word(input logic [31:0] w, input logic exp_zero, input string name);
    bus.ser_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s idle in_ready: got %b want 1", name, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) begin
      #1;
      tests_run++;
      if (bus.ser_valid !== 1'b1 || bus.ser_bit !== w[i] ||
          bus.ser_last !== (i == 31) || bus.in_ready !== (i == 31)) begin
        tests_failed++;
        $display("FAIL %s beat %0d: got valid=%b bit=%b last=%b rdy=%b want 1 %b %b %b",
                 name, i, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.in_ready,
                 w[i], (i == 31), (i == 31));
      end
      @(negedge clk);
    end
    tests_run++;
    if (bus.word_done !== 1'b1 || bus.word_zero !== exp_zero || bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done: got done=%b zero=%b valid=%b want 1 %b 0",
               name, bus.word_done, bus.word_zero, bus.ser_valid, exp_zero);
    end
    @(negedge clk);
    tests_run++;
    if (bus.word_done !== 1'b0 || bus.word_zero !== exp_zero) begin
      tests_failed++;
      $display("FAIL %s done pulse width: got done=%b zero=%b want 0 %b",
               name, bus.word_done, bus.word_zero, exp_zero);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.ser_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.ser_valid !== 1'b0 || bus.ser_bit !== 1'b0 || bus.ser_last !== 1'b0 ||
        bus.word_zero !== 1'b0 || bus.word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset outputs: got valid=%b bit=%b last=%b zero=%b done=%b want all 0",
               bus.ser_valid, bus.ser_bit, bus.ser_last, bus.word_zero, bus.word_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset release: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.ser_valid);
    end
  endtask

  task automatic test_basic();
    test_word(32'h0000_0001, 1'b0, "basic");
  endtask

  task automatic test_zero();
    test_word(32'h0000_0000, 1'b1, "zero");
    test_word(32'h8000_0000, 1'b0, "msb_only");
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int          beats;
    int          cyc;
    w     = 32'hA5A5_A5A5;
    beats = 0;
    cyc   = 0;
    @(negedge clk);
    bus.ser_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    // ser_ready pattern repeats 1,0,0 every three cycles.
    while (beats < 32 && cyc < 200) begin
      bus.ser_ready = (cyc % 3 == 0);
      #1;
      tests_run++;
      if (bus.ser_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL backpressure valid drop cyc %0d: got %b want 1", cyc, bus.ser_valid);
      end
      if (bus.ser_ready) begin
        tests_run++;
        if (bus.ser_bit !== w[beats] || bus.ser_last !== (beats == 31)) begin
          tests_failed++;
          $display("FAIL backpressure beat %0d: got bit=%b last=%b want %b %b",
                   beats, bus.ser_bit, bus.ser_last, w[beats], (beats == 31));
        end
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    tests_run++;
    if (beats != 32 || bus.word_done !== 1'b1 || bus.word_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure end: got beats=%0d done=%b zero=%b want 32 1 0",
               beats, bus.word_done, bus.word_zero);
    end
    bus.ser_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    bus.ser_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.in_data = 32'h0000_0000;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) bus.in_valid = 1'b0;
      exp_bit = (i < 32);
      #1;
      tests_run++;
      if (bus.ser_valid !== 1'b1 || bus.ser_bit !== exp_bit ||
          bus.ser_last !== (i % 32 == 31) || bus.in_ready !== (i % 32 == 31)) begin
        tests_failed++;
        $display("FAIL b2b beat %0d: got valid=%b bit=%b last=%b rdy=%b want 1 %b %b %b",
                 i, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.in_ready,
                 exp_bit, (i % 32 == 31), (i % 32 == 31));
      end
      if (i == 32 || i == 33) begin
        tests_run++;
        if (bus.word_done !== (i == 32) || bus.word_zero !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b first done at %0d: got done=%b zero=%b want %b 0",
                   i, bus.word_done, bus.word_zero, (i == 32));
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (bus.word_done !== 1'b1 || bus.word_zero !== 1'b1 || bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b second done: got done=%b zero=%b valid=%b want 1 1 0",
               bus.word_done, bus.word_zero, bus.ser_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    w = 32'h1234_5678;
    bus.ser_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (bus.ser_bit !== w[i]) begin
        tests_failed++;
        $display("FAIL midreset pre beat %0d: got %b want %b", i, bus.ser_bit, w[i]);
      end
      @(negedge clk);
    end
    // Asserted between clock edges, so the check below only passes if reset is asynchronous.
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ser_valid !== 1'b0 || bus.ser_bit !== 1'b0 || bus.ser_last !== 1'b0 ||
        bus.word_zero !== 1'b0 || bus.word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset async: got valid=%b bit=%b last=%b zero=%b done=%b want all 0",
               bus.ser_valid, bus.ser_bit, bus.ser_last, bus.word_zero, bus.word_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.word_done !== 1'b0 || bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset release: got rdy=%b done=%b valid=%b want 1 0 0",
               bus.in_ready, bus.word_done, bus.ser_valid);
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (bus.word_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset spurious done: got %b want 0", bus.word_done);
      end
    end
    test_word(32'h0000_0001, 1'b0, "after_reset");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_word_serializer32
